// File: rtl/button_event.sv
// button_event: turns a debounced button level into press/release/short/long/repeat pulses.
// Auto-repeat (repeat_pulse, repeat_count) is built only when BTN_EVT_REPEAT_EN is defined.
module button_event #(
    parameter int LONG_CYCLES   = 1_000_000,
    parameter int REPEAT_CYCLES = 250_000,
    localparam int CNT_W = $clog2(((LONG_CYCLES > REPEAT_CYCLES) ?
                                   LONG_CYCLES : REPEAT_CYCLES) + 1)
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       enable,
    input  logic       btn_level,
    output logic       press_pulse,
    output logic       release_pulse,
    output logic       short_pulse,
    output logic       long_pulse,
    output logic       repeat_pulse,
    output logic       held,
    output logic       long_active,
    output logic [7:0] repeat_count
);

    typedef enum logic [1:0] {
        IDLE,
        PRESSED,
        LONG
    } state_t;

    state_t           state;
    logic             prev;
    logic [CNT_W-1:0] hold_cnt;
    logic [CNT_W-1:0] hold_nxt;
    logic             press_edge;

    assign hold_nxt   = hold_cnt + CNT_W'(1);
    assign press_edge = btn_level & ~prev;

    // prev follows the button even while disabled, so a held button stays silent
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) prev <= 1'b0;
        else          prev <= btn_level;
    end

`ifdef BTN_EVT_REPEAT_EN
    logic [CNT_W-1:0] rep_cnt;
    logic [CNT_W-1:0] rep_nxt;
    assign rep_nxt = rep_cnt + CNT_W'(1);
`else
    assign repeat_pulse = 1'b0;
    assign repeat_count = 8'd0;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= IDLE;
            hold_cnt      <= '0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            short_pulse   <= 1'b0;
            long_pulse    <= 1'b0;
            held          <= 1'b0;
            long_active   <= 1'b0;
`ifdef BTN_EVT_REPEAT_EN
            rep_cnt       <= '0;
            repeat_pulse  <= 1'b0;
            repeat_count  <= 8'd0;
`endif
        end else begin
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            short_pulse   <= 1'b0;
            long_pulse    <= 1'b0;
`ifdef BTN_EVT_REPEAT_EN
            repeat_pulse  <= 1'b0;
`endif
            if (!enable) begin
                state       <= IDLE;
                hold_cnt    <= '0;
                held        <= 1'b0;
                long_active <= 1'b0;
`ifdef BTN_EVT_REPEAT_EN
                rep_cnt      <= '0;
                repeat_count <= 8'd0;
`endif
            end else begin
                unique case (state)
                    IDLE: begin
                        if (press_edge) begin
                            state       <= PRESSED;
                            hold_cnt    <= '0;
                            press_pulse <= 1'b1;
                            held        <= 1'b1;
`ifdef BTN_EVT_REPEAT_EN
                            repeat_count <= 8'd0;
`endif
                        end
                    end
                    PRESSED: begin
                        if (!btn_level) begin
                            state         <= IDLE;
                            release_pulse <= 1'b1;
                            short_pulse   <= 1'b1;
                            held          <= 1'b0;
                        end else if (hold_nxt == CNT_W'(LONG_CYCLES)) begin
                            state       <= LONG;
                            hold_cnt    <= hold_nxt;
                            long_pulse  <= 1'b1;
                            long_active <= 1'b1;
`ifdef BTN_EVT_REPEAT_EN
                            rep_cnt <= '0;
`endif
                        end else begin
                            hold_cnt <= hold_nxt;
                        end
                    end
                    LONG: begin
                        if (!btn_level) begin
                            state         <= IDLE;
                            release_pulse <= 1'b1;
                            held          <= 1'b0;
                            long_active   <= 1'b0;
                        end
`ifdef BTN_EVT_REPEAT_EN
                        else if (rep_nxt == CNT_W'(REPEAT_CYCLES)) begin
                            rep_cnt      <= '0;
                            repeat_pulse <= 1'b1;
                            if (repeat_count != 8'hFF)
                                repeat_count <= repeat_count + 8'd1;
                        end else begin
                            rep_cnt <= rep_nxt;
                        end
`endif
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_button_event.sv
// tb_button_event: random and directed stimulus for two button_event instances
// (REPEAT_CYCLES 4 and 1) checked every cycle against a press-timing model.
module tb_button_event;

    localparam int LONG_C = 10;
`ifdef BTN_EVT_REPEAT_EN
    localparam bit REP_EN = 1'b1;
`else
    localparam bit REP_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       enable = 1'b1;
    logic       btn = 1'b0;
    logic       pp[2], rl[2], sp[2], lp[2], rp[2], hd[2], la[2];
    logic [7:0] rc[2];

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    bit m_prev;
    bit act[2];
    int k0[2];
    int m_rc[2];
    bit e_pp[2], e_rl[2], e_sp[2], e_lp[2], e_rp[2], e_hd[2], e_la[2];

    always #5 clk = ~clk;

    button_event #(.LONG_CYCLES(LONG_C), .REPEAT_CYCLES(4)) dut0 (
        .clk(clk), .reset_n(reset_n), .enable(enable), .btn_level(btn),
        .press_pulse(pp[0]), .release_pulse(rl[0]), .short_pulse(sp[0]),
        .long_pulse(lp[0]), .repeat_pulse(rp[0]), .held(hd[0]),
        .long_active(la[0]), .repeat_count(rc[0])
    );

    button_event #(.LONG_CYCLES(LONG_C), .REPEAT_CYCLES(1)) dut1 (
        .clk(clk), .reset_n(reset_n), .enable(enable), .btn_level(btn),
        .press_pulse(pp[1]), .release_pulse(rl[1]), .short_pulse(sp[1]),
        .long_pulse(lp[1]), .repeat_pulse(rp[1]), .held(hd[1]),
        .long_active(la[1]), .repeat_count(rc[1])
    );

    function automatic int rep_of(input int i);
        return (i == 0) ? 4 : 1;
    endfunction

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        if (obs != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic clear_pulses();
        for (int i = 0; i < 2; i++) begin
            e_pp[i] = 0; e_rl[i] = 0; e_sp[i] = 0;
            e_lp[i] = 0; e_rp[i] = 0;
        end
    endtask

    task automatic model_reset();
        clear_pulses();
        m_prev = 0;
        for (int i = 0; i < 2; i++) begin
            act[i] = 0; m_rc[i] = 0; e_hd[i] = 0; e_la[i] = 0;
        end
    endtask

    // events derived from elapsed edges since the press edge k0
    task automatic model_step();
        clear_pulses();
        for (int i = 0; i < 2; i++) begin
            int j;
            j = cyc - k0[i];
            if (!enable) begin
                act[i] = 0;
                m_rc[i] = 0;
            end else if (!act[i]) begin
                if (btn && !m_prev) begin
                    act[i] = 1; k0[i] = cyc; m_rc[i] = 0; e_pp[i] = 1;
                end
            end else if (!btn) begin
                e_rl[i] = 1;
                e_sp[i] = (j <= LONG_C);
                act[i] = 0;
            end else if (j == LONG_C) begin
                e_lp[i] = 1;
            end else if (REP_EN && j > LONG_C && (j - LONG_C) % rep_of(i) == 0) begin
                e_rp[i] = 1;
                if (m_rc[i] < 255) m_rc[i]++;
            end
            e_hd[i] = act[i];
            e_la[i] = act[i] && (cyc - k0[i]) >= LONG_C;
        end
        m_prev = btn;
    endtask

    task automatic check_all();
        for (int i = 0; i < 2; i++) begin
            check($sformatf("press%0d@%0d", i, cyc), pp[i], e_pp[i]);
            check($sformatf("release%0d@%0d", i, cyc), rl[i], e_rl[i]);
            check($sformatf("short%0d@%0d", i, cyc), sp[i], e_sp[i]);
            check($sformatf("long%0d@%0d", i, cyc), lp[i], e_lp[i]);
            check($sformatf("repeat%0d@%0d", i, cyc), rp[i], e_rp[i]);
            check($sformatf("held%0d@%0d", i, cyc), hd[i], e_hd[i]);
            check($sformatf("long_active%0d@%0d", i, cyc), la[i], e_la[i]);
            check($sformatf("repeat_count%0d@%0d", i, cyc), rc[i], m_rc[i]);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        cyc++;
        @(negedge clk);
        check_all();
    endtask

    task automatic press(input int n);
        btn = 1;
        repeat (n) tick();
        btn = 0;
        tick();
    endtask

    initial begin
        model_reset();
        #2;
        check_all();
        @(negedge clk);
        reset_n = 1;
        tick();
        tick();

        press(4);
        press(10);
        press(11);
        press(23);
        press(3);
        press(2);
        press(5);

        btn = 1;
        repeat (5) tick();
        enable = 0;
        repeat (3) tick();
        enable = 1;
        repeat (23) tick();
        btn = 0;
        tick();
        press(3);

        btn = 1;
        repeat (12) tick();
        reset_n = 0;
        #1;
        model_reset();
        check_all();
        repeat (2) @(negedge clk);
        reset_n = 1;
        tick();
        btn = 0;
        tick();

        press(300);
        tick();

        repeat (800) begin
            if ($urandom_range(0, 11) == 0) btn = ~btn;
            if ($urandom_range(0, 59) == 0) enable = ~enable;
            tick();
        end
        enable = 1;
        btn = 0;
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/button_event.md
Name: button_event

Overview:
- Sits directly downstream of the stopwatch button debouncer and consumes its clean, synchronised, active-high level.
- Converts that level into single-cycle events: press, release, short press, long press and optional auto-repeat.
- Drives the stopwatch control FSM (start/stop, lap, reset-on-long-press, fast-set).
- Holds one button; instantiate once per button.

Parameters:
- LONG_CYCLES, 1_000_000, sampled-high cycles after the press edge needed to declare a long press; legal range >= 2.
- REPEAT_CYCLES, 250_000, auto-repeat period in cycles once in long-press; legal range >= 1.
- CNT_W, $clog2(max(LONG_CYCLES,REPEAT_CYCLES)+1), internal counter width; derived, not overridden.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  reset, asynchronous, active-low.
- enable  in  1  block enable; low forces IDLE synchronously.
- btn_level  in  1  debounced button level, 1 = pressed, already synchronous to clk.
- press_pulse  out  1  one-cycle pulse on press.
- release_pulse  out  1  one-cycle pulse on any release.
- short_pulse  out  1  one-cycle pulse on release before the long threshold.
- long_pulse  out  1  one-cycle pulse when the long threshold is reached.
- repeat_pulse  out  1  one-cycle auto-repeat pulse.
- held  out  1  high while in PRESSED or LONG.
- long_active  out  1  high while in LONG.
- repeat_count  out  8  repeats since the current press, saturating.

Behaviour:
- All outputs are registered. Reset value of every output and of internal state is 0; state resets to IDLE.
- Reset is asynchronous: outputs drop immediately when reset_n goes low, including mid-press.
- prev register samples btn_level on every clk edge, regardless of enable; reset value 0.
- Let edge k0 be the clk edge where btn_level=1 and prev=0 with enable=1 and state IDLE.
- FSM states: IDLE, PRESSED, LONG.
- IDLE -> PRESSED at k0:
  - press_pulse high for the cycle after k0.
  - hold_cnt cleared to 0; repeat_count cleared to 0.
- PRESSED:
  - hold_cnt increments on each edge where btn_level=1.
  - btn_level=0 at edge k0+j, 1<=j<=LONG_CYCLES: release_pulse and short_pulse high together for one cycle; -> IDLE.
  - btn_level=1 at edges k0+1..k0+LONG_CYCLES: long_pulse high after edge k0+LONG_CYCLES (LONG_CYCLES cycles after press_pulse); -> LONG; repeat counter cleared.
  - Release sampled at the threshold edge wins: short press, no long_pulse.
- LONG:
  - With the repeat feature: repeat_pulse after edges k0+LONG_CYCLES+m*REPEAT_CYCLES for m>=1 while btn_level stays 1.
  - Each repeat_pulse increments repeat_count; it saturates at 255 and never wraps.
  - btn_level=0 at any edge: release_pulse only (no short_pulse); -> IDLE. Release at a repeat edge suppresses that repeat.
- At most one of press/long/repeat pulses per cycle. release_pulse coincides only with short_pulse.
- enable=0:
  - Next edge forces IDLE, clears counters and all outputs (repeat_count included); no pulses are emitted.
  - Because prev keeps tracking, a button still held when enable returns high generates nothing until it is released and pressed again.
- Back-to-back press in the cycle right after a release is detected normally (prev=0 then 1).

Optional Feature:
- Macro BTN_EVT_REPEAT_EN.
- Defined: auto-repeat counter, repeat_pulse and repeat_count are implemented as above.
- Undefined: the repeat counter logic is not synthesised; repeat_pulse and repeat_count are tied to 0; LONG waits only for release. All other timing is unchanged.

Test Plan:
- Bench parameters: LONG_CYCLES=10, REPEAT_CYCLES=4, BTN_EVT_REPEAT_EN defined, enable=1 unless stated.
- Short press: btn high at k0 through k0+3, low at k0+4 -> press_pulse after k0; release_pulse and short_pulse after k0+4; no long_pulse; held low after k0+4.
- Threshold boundary: low sampled at k0+10 -> short_pulse, no long_pulse. Repeat with low sampled first at k0+11 -> long_pulse after k0+10, long_active=1; release gives release_pulse only.
- Auto-repeat: hold through k0+22, release at k0+23 -> repeat_pulse after k0+14, k0+18, k0+22; repeat_count=3; then release_pulse; next press resets repeat_count to 0.
- Enable gating: drop enable at k0+5 while held, raise at k0+8, hold to k0+30 -> no pulses after k0+5, held=0. Release then press again -> normal press_pulse.
- Reset and saturation:
  - reset_n low at k0+12 -> all outputs 0 immediately, state IDLE.
  - With REPEAT_CYCLES=1, hold 300 cycles -> repeat_count stops at 255.
  - With BTN_EVT_REPEAT_EN undefined -> repeat_pulse never asserts.
